// File: rtl/intersection_phase_arbiter.sv
// -----------------------------------------------------------------------------
// intersection_phase_arbiter
//
// Signal controller for a two-approach intersection (A, B) with a pedestrian
// crossing (W). Pending requests are served round-robin. Each approach runs
// GREEN -> YELLOW -> CLEAR. The walk phase runs WALK -> FLASH -> CLEAR. A
// maintenance request overrides everything and puts the reds into a blink.
// Phase lengths are counted in ticks. One tick is TICK_DIV clocks.
//
// Ports
//   clk                    rising-edge clock
//   reset                  asynchronous, active-low reset
//   req_a, req_b, req_w    approach A / approach B sensors, pedestrian button
//   maint                  maintenance request (sampled on clk)
//   Ga Ya Ra               approach A lamps (registered)
//   Gb Yb Rb               approach B lamps (registered)
//   Gw Rw                  pedestrian lamps (registered)
//   grant[2:0]             one-hot current grant, bit0=A bit1=B bit2=W
//   phase[2:0]             current state code
//   busy                   high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module intersection_phase_arbiter #(
    parameter int TICK_DIV = 10,
    parameter int T_GMIN   = 4,
    parameter int T_GMAX   = 12,
    parameter int T_YEL    = 3,
    parameter int T_WALK   = 6,
    parameter int T_FLASH  = 4,
    parameter int T_CLR    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       req_w,
    input  logic       maint,
    output logic       Ga,
    output logic       Ya,
    output logic       Ra,
    output logic       Gb,
    output logic       Yb,
    output logic       Rb,
    output logic       Gw,
    output logic       Rw,
    output logic [2:0] grant,
    output logic [2:0] phase,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GREEN  = 3'd1,
        S_YELLOW = 3'd2,
        S_WALK   = 3'd3,
        S_FLASH  = 3'd4,
        S_CLEAR  = 3'd5,
        S_MAINT  = 3'd6
    } state_t;

    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);
    localparam logic [7:0] GMIN      = 8'(T_GMIN);
    localparam logic [7:0] GMAX      = 8'(T_GMAX);
    localparam logic [7:0] YEL       = 8'(T_YEL);
    localparam logic [7:0] WALK      = 8'(T_WALK);
    localparam logic [7:0] FLASH     = 8'(T_FLASH);
    localparam logic [7:0] CLR       = 8'(T_CLR);
    localparam logic [2:0] GRANT_W   = 3'b100;

    // Lamp vector bit positions: {Ga, Ya, Ra, Gb, Yb, Rb, Gw, Rw}
    localparam int L_GA = 7;
    localparam int L_YA = 6;
    localparam int L_RA = 5;
    localparam int L_GB = 4;
    localparam int L_YB = 3;
    localparam int L_RB = 2;
    localparam int L_GW = 1;
    localparam int L_RW = 0;
    localparam logic [7:0] LAMPS_ALL_RED = 8'b0010_0101;

    state_t     state_q, state_d;
    logic [2:0] grant_q, grant_d;
    logic [2:0] last_q, last_d;
    logic [2:0] pending_q, pending_d;
    logic [7:0] presc_q, presc_d;
    logic [7:0] timer_q, timer_d;
    logic       blink_q, blink_d;
    logic [7:0] lamps_q, lamps_d;

    logic [2:0] req_vec;
    logic [2:0] win;
    logic [2:0] hold_vec;
    logic [7:0] timer_inc;
    logic       tick;
    logic       entry;
    logic       green_done;

    // Round-robin pick: the search starts at the requester after the last
    // grant and wraps A -> B -> W -> A.
    function automatic logic [2:0] rr_pick(input logic [2:0] pend, input logic [2:0] last);
        logic [2:0] pick;
        pick = '0;
        case (last)
            3'b001: begin
                if      (pend[1]) pick = 3'b010;
                else if (pend[2]) pick = 3'b100;
                else if (pend[0]) pick = 3'b001;
            end
            3'b010: begin
                if      (pend[2]) pick = 3'b100;
                else if (pend[0]) pick = 3'b001;
                else if (pend[1]) pick = 3'b010;
            end
            default: begin
                if      (pend[0]) pick = 3'b001;
                else if (pend[1]) pick = 3'b010;
                else if (pend[2]) pick = 3'b100;
            end
        endcase
        return pick;
    endfunction

    assign req_vec   = {req_w, req_b, req_a};
    assign win       = rr_pick(pending_q, last_q);
    assign tick      = (presc_q == TICK_LAST);
    assign timer_inc = timer_q + 8'd1;
    assign entry     = (state_d != state_q);

    // Phase-end tests use the incremented timer on the tick cycle. This makes
    // a phase held N ticks last exactly N*TICK_DIV clocks.
    assign green_done = tick && ((timer_inc == GMAX) ||
                                 ((timer_inc >= GMIN) &&
                                  ((|(pending_q & ~grant_q)) || !(|(req_vec & grant_q)))));

    // -------------------------------------------------------------------------
    // State register and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            last_q    <= GRANT_W;
            pending_q <= '0;
            presc_q   <= '0;
            timer_q   <= '0;
            blink_q   <= 1'b1;
            lamps_q   <= LAMPS_ALL_RED;
        end else begin
            // NOTE: non-blocking assignments update every register from
            // pre-edge values, so the order of these lines does not matter.
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            pending_q <= pending_d;
            presc_q   <= presc_d;
            timer_q   <= timer_d;
            blink_q   <= blink_d;
            lamps_q   <= lamps_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first.
        // Otherwise a path that skips an assignment infers a latch.
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;

        unique case (state_q)
            S_IDLE: begin
                if (|pending_q) begin
                    state_d = win[2] ? S_WALK : S_GREEN;
                    grant_d = win;
                    last_d  = win;
                end
            end
            S_GREEN: begin
                if (green_done) state_d = S_YELLOW;
            end
            S_YELLOW: begin
                if (tick && timer_inc == YEL) state_d = S_CLEAR;
            end
            S_WALK: begin
                if (tick && timer_inc == WALK) state_d = S_FLASH;
            end
            S_FLASH: begin
                if (tick && timer_inc == FLASH) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (tick && timer_inc == CLR) begin
                    if (|pending_q) begin
                        state_d = win[2] ? S_WALK : S_GREEN;
                        grant_d = win;
                        last_d  = win;
                    end else begin
                        state_d = S_IDLE;
                        grant_d = '0;
                    end
                end
            end
            S_MAINT: begin
                if (!maint) state_d = S_CLEAR;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        // Maintenance overrides any transition decided above.
        if (maint) begin
            state_d = S_MAINT;
            grant_d = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Prescaler, tick timer, blink phase and request latching
    // -------------------------------------------------------------------------
    always_comb begin
        presc_d = presc_q + 8'd1;
        timer_d = timer_q;
        blink_d = blink_q;
        if (entry) begin
            presc_d = '0;
            timer_d = '0;
            blink_d = 1'b1;
        end else if (tick) begin
            presc_d = '0;
            timer_d = timer_inc;
            blink_d = ~blink_q;
        end

        // A requester being served does not re-latch its own request.
        hold_vec  = (state_q == S_GREEN || state_q == S_WALK) ? grant_q : 3'b000;
        pending_d = pending_q | (req_vec & ~hold_vec);
        if (entry && (state_d == S_GREEN || state_d == S_WALK))
            pending_d = pending_d & ~grant_d;
        if (state_d == S_MAINT)
            pending_d = '0;
    end

    // -------------------------------------------------------------------------
    // Lamp decode. It uses the next-state values so the registered lamps
    // change on the same edge as the state.
    // -------------------------------------------------------------------------
    always_comb begin
        lamps_d = LAMPS_ALL_RED;
        unique case (state_d)
            S_GREEN: begin
                if (grant_d[0]) begin lamps_d[L_GA] = 1'b1; lamps_d[L_RA] = 1'b0; end
                if (grant_d[1]) begin lamps_d[L_GB] = 1'b1; lamps_d[L_RB] = 1'b0; end
            end
            S_YELLOW: begin
                if (grant_d[0]) begin lamps_d[L_YA] = 1'b1; lamps_d[L_RA] = 1'b0; end
                if (grant_d[1]) begin lamps_d[L_YB] = 1'b1; lamps_d[L_RB] = 1'b0; end
            end
            S_WALK: begin
                lamps_d[L_GW] = 1'b1;
                lamps_d[L_RW] = 1'b0;
            end
            S_FLASH: begin
                lamps_d[L_RW] = blink_d;
            end
            S_MAINT: begin
                lamps_d[L_RA] = blink_d;
                lamps_d[L_RB] = blink_d;
                lamps_d[L_RW] = blink_d;
            end
            default: begin
                lamps_d = LAMPS_ALL_RED;
            end
        endcase
    end

    assign {Ga, Ya, Ra, Gb, Yb, Rb, Gw, Rw} = lamps_q;
    assign grant = grant_q;
    assign phase = state_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for intersection_phase_arbiter. Each scenario queues the expected
// sequence of output segments: {phase, grant, lamps} and how many clocks
// each one lasts. A monitor splits the DUT outputs into runs of constant
// value and compares each completed run with the head of the queue.
// -----------------------------------------------------------------------------
module tb_intersection_phase_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a, req_b, req_w, maint;
    logic       Ga, Ya, Ra, Gb, Yb, Rb, Gw, Rw;
    logic [2:0] grant;
    logic [2:0] phase;
    logic       busy;

    always #5 clk = ~clk;

    intersection_phase_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .req_a (req_a),
        .req_b (req_b),
        .req_w (req_w),
        .maint (maint),
        .Ga    (Ga),
        .Ya    (Ya),
        .Ra    (Ra),
        .Gb    (Gb),
        .Yb    (Yb),
        .Rb    (Rb),
        .Gw    (Gw),
        .Rw    (Rw),
        .grant (grant),
        .phase (phase),
        .busy  (busy)
    );

    // Lamp patterns {Ga,Ya,Ra,Gb,Yb,Rb,Gw,Rw}
    localparam logic [7:0] L_RED   = 8'b0010_0101;
    localparam logic [7:0] L_GA    = 8'b1000_0101;
    localparam logic [7:0] L_YA    = 8'b0100_0101;
    localparam logic [7:0] L_GB    = 8'b0011_0001;
    localparam logic [7:0] L_YB    = 8'b0010_1001;
    localparam logic [7:0] L_WALK  = 8'b0010_0110;
    localparam logic [7:0] L_RW0   = 8'b0010_0100;
    localparam logic [7:0] L_DARK  = 8'b0000_0000;

    localparam logic [2:0] P_IDLE = 3'd0, P_GREEN = 3'd1, P_YELLOW = 3'd2,
                           P_WALK = 3'd3, P_FLASH = 3'd4, P_CLEAR = 3'd5,
                           P_MAINT = 3'd6;

    typedef struct {
        logic [13:0] v;
        int          len;   // 0: length not checked
    } seg_t;

    seg_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   seg_no  = 0;
    bit   mon_en  = 1'b0;
    bit   have_prev = 1'b0;
    logic [13:0] prev_v;
    logic [13:0] cur_v;
    int   run_len = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [2:0] ph, input logic [2:0] g, input logic [7:0] l, input int len);
        seg_t s;
        s.v   = {ph, g, l};
        s.len = len;
        sb.push_back(s);
    endtask

    task automatic close_segment(input logic [13:0] v, input int len);
        seg_t s;
        seg_no++;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL seg%0d_extra: got 0x%0h len %0d expected no segment", seg_no, v, len);
        end else begin
            s = sb.pop_front();
            check($sformatf("seg%0d_state", seg_no), 32'(v), 32'(s.v));
            if (s.len != 0)
                check($sformatf("seg%0d_len", seg_no), 32'(len), 32'(s.len));
        end
    endtask

    // Segment monitor, sampled on the inactive clock edge.
    always @(negedge clk) begin
        cur_v = {phase, grant, Ga, Ya, Ra, Gb, Yb, Rb, Gw, Rw};
        if (!mon_en) begin
            have_prev = 1'b0;
        end else if (!have_prev) begin
            prev_v    = cur_v;
            run_len   = 1;
            have_prev = 1'b1;
        end else if (cur_v == prev_v) begin
            run_len++;
        end else begin
            close_segment(prev_v, run_len);
            prev_v  = cur_v;
            run_len = 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((phase != P_IDLE || sb.size() != 0) && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_idle_phase"}, 32'(phase), 32'(P_IDLE));
        check({tag, "_queue_empty"}, 32'(sb.size()), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_phase"}, 32'(phase), 32'(P_IDLE));
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_lamps"}, 32'({Ga, Ya, Ra, Gb, Yb, Rb, Gw, Rw}), 32'(L_RED));
    endtask

    task automatic push_a(input int green_len);
        push(P_GREEN,  3'b001, L_GA,  green_len);
        push(P_YELLOW, 3'b001, L_YA,  30);
        push(P_CLEAR,  3'b001, L_RED, 20);
    endtask

    task automatic push_b();
        push(P_GREEN,  3'b010, L_GB,  40);
        push(P_YELLOW, 3'b010, L_YB,  30);
        push(P_CLEAR,  3'b010, L_RED, 20);
    endtask

    // A and B requested on the same cycle: A first, then B straight out of CLEAR.
    task automatic scenario_ab(input string tag);
        push(P_IDLE, 3'b000, L_RED, 0);
        push_a(40);
        push_b();
        req_a = 1'b1; req_b = 1'b1;
        step();
        req_a = 1'b0; req_b = 1'b0;
        wait_idle(tag);
    endtask

    initial begin
        reset = 1'b0;
        req_a = 1'b0; req_b = 1'b0; req_w = 1'b0; maint = 1'b0;
        #12;
        check_reset_vals("por");
        #11 reset = 1'b1;
        step();
        mon_en = 1'b1;
        repeat (3) step();

        // Simultaneous A and B after reset
        scenario_ab("ab");

        // Single A pulse: Ga appears two edges after the request is driven
        push(P_IDLE, 3'b000, L_RED, 0);
        push_a(40);
        req_a = 1'b1;
        step();
        check("a_pulse_ga_edge1", 32'(Ga), 32'd0);
        req_a = 1'b0;
        step();
        check("a_pulse_ga_edge2", 32'(Ga), 32'd1);
        wait_idle("a_pulse");

        // A held: green runs to the maximum
        push(P_IDLE, 3'b000, L_RED, 0);
        push_a(120);
        req_a = 1'b1;
        repeat (122) step();
        req_a = 1'b0;
        wait_idle("a_max");

        // A held, B arrives at tick 2: A's green ends at tick 4, then B
        push(P_IDLE, 3'b000, L_RED, 0);
        push_a(40);
        push_b();
        req_a = 1'b1;
        repeat (22) step();
        req_b = 1'b1;
        step();
        req_b = 1'b0;
        repeat (19) step();
        req_a = 1'b0;
        wait_idle("a_b_gap");

        // Pedestrian: walk, flashing Rw, clearance
        push(P_IDLE,  3'b000, L_RED,  0);
        push(P_WALK,  3'b100, L_WALK, 60);
        push(P_FLASH, 3'b100, L_RED,  10);
        push(P_FLASH, 3'b100, L_RW0,  10);
        push(P_FLASH, 3'b100, L_RED,  10);
        push(P_FLASH, 3'b100, L_RW0,  10);
        push(P_CLEAR, 3'b100, L_RED,  20);
        req_w = 1'b1;
        step();
        req_w = 1'b0;
        wait_idle("walk");

        // Maintenance during green A; a B request during MAINT is discarded
        push(P_IDLE,  3'b000, L_RED,  0);
        push(P_GREEN, 3'b001, L_GA,   16);
        push(P_MAINT, 3'b000, L_RED,  10);
        push(P_MAINT, 3'b000, L_DARK, 10);
        push(P_MAINT, 3'b000, L_RED,  10);
        push(P_MAINT, 3'b000, L_DARK, 6);
        push(P_CLEAR, 3'b000, L_RED,  20);
        req_a = 1'b1;
        step();
        req_a = 1'b0;
        repeat (16) step();
        maint = 1'b1;
        repeat (13) step();
        req_b = 1'b1;
        step();
        req_b = 1'b0;
        repeat (22) step();
        maint = 1'b0;
        wait_idle("maint");

        // Reset mid-yellow B, then A and B pending: A wins
        push(P_IDLE,  3'b000, L_RED, 0);
        push(P_GREEN, 3'b010, L_GB,  40);
        req_b = 1'b1;
        step();
        req_b = 1'b0;
        repeat (49) step();
        check("rst_pre_phase", 32'(phase), 32'(P_YELLOW));
        check("rst_pre_grant", 32'(grant), 32'b010);
        check("rst_pre_queue", 32'(sb.size()), 32'd0);
        mon_en = 1'b0;
        sb.delete();
        #2 reset = 1'b0;
        #1;
        check_reset_vals("rst_async");
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        step();
        mon_en = 1'b1;
        step();
        scenario_ab("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
